qrs_peak_locator: RTL and testbench

Consumer end of the threshold interface in the DF peak-detection chain. Takes the windowed maximum `maxval` and its `enable` strobe from the threshold stage, derives a detection threshold, and scans the detail-coefficient stream `cd3` for supra-threshold episodes. For each qualifying episode it reports the sample address and value of the local maximum (the R-peak) on a valid/ready output port. Sits between the threshold stage and the downstream peak/RR consumers inside the DF block.

---
 rtl/qrs_peak_if.sv | 37 +++
 rtl/qrs_peak_locator.sv | 166 ++++++++++++++++
 tb/tb_qrs_peak_locator.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qrs_peak_if.sv
// qrs_peak_if: connects the threshold stage and the cd3 sample stream to qrs_peak_locator,
// and carries the peak record from qrs_peak_locator to the downstream consumers.
// The master modport is the side that drives the threshold and the samples and that accepts
// peak records. The slave modport is the locator itself.
// When QRS_RR_INTERVAL_EN is defined, the peak record also carries rr_interval.
interface qrs_peak_if;
  logic        enable;
  logic [15:0] maxval;
  logic        cd3_valid;
  logic [15:0] cd3;
  logic        peak_valid;
  logic        peak_ready;
  logic [31:0] peak_addr;
  logic [15:0] peak_val;
  logic        overflow;
`ifdef QRS_RR_INTERVAL_EN
  logic [31:0] rr_interval;

  modport master (
    output enable, maxval, cd3_valid, cd3, peak_ready,
    input  peak_valid, peak_addr, peak_val, overflow, rr_interval
  );
  modport slave (
    input  enable, maxval, cd3_valid, cd3, peak_ready,
    output peak_valid, peak_addr, peak_val, overflow, rr_interval
  );
`else
  modport master (
    output enable, maxval, cd3_valid, cd3, peak_ready,
    input  peak_valid, peak_addr, peak_val, overflow
  );
  modport slave (
    input  enable, maxval, cd3_valid, cd3, peak_ready,
    output peak_valid, peak_addr, peak_val, overflow
  );
`endif
endinterface

// File: rtl/qrs_peak_locator.sv
// qrs_peak_locator: finds R-peaks in the cd3 detail stream.
// The threshold is (maxval * THR_NUM) >> 3. The block scans cd3 for episodes that stay above
// the threshold. For each episode of at least MIN_W samples it emits the address and value of
// the first maximum sample, then ignores the next REFRACT samples.
// Output is a single-slot valid/ready record. A peak that arrives while the record is still
// pending is dropped and sets the sticky overflow flag.
// Optional feature: define QRS_RR_INTERVAL_EN to add rr_interval, which is the distance in
// samples from the previous loaded peak.
// SIDX_INIT is the reset value of the sample index. The default of 0 is the normal value.
module qrs_peak_locator #(
  parameter int unsigned THR_NUM   = 5,
  parameter int unsigned MIN_W     = 3,
  parameter int unsigned REFRACT   = 40,
  parameter logic [31:0] SIDX_INIT = 32'd0
) (
  input  logic      clk3,
  input  logic      rst_n,
  qrs_peak_if.slave bus
);

  localparam int unsigned     RC_W    = (REFRACT > 1) ? $clog2(REFRACT) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRACT - 1);
  localparam logic [7:0]      LEN_MIN = 8'(MIN_W);

  typedef enum logic [1:0] {S_WAIT_THR, S_IDLE, S_ABOVE, S_REFRACT} state_t;

  state_t          state, state_nx;
  logic [19:0]     thr_prod;
  logic [15:0]     thr;
  logic [31:0]     sidx;
  logic [15:0]     max_v;
  logic [31:0]     max_idx;
  logic [7:0]      len;
  logic [RC_W-1:0] rcnt;
  logic            above;
  logic            emit;
  logic            peak_valid_q;
  logic [31:0]     peak_addr_q;
  logic [15:0]     peak_val_q;
  logic            overflow_q;

  // 20-bit product; the >> 3 result always fits in 16 bits for THR_NUM <= 8.
  assign thr_prod = {4'd0, bus.maxval} * 20'(THR_NUM);
  assign above    = bus.cd3 > thr;

  // Threshold register and the index of the current sample.
  always_ff @(posedge clk3 or negedge rst_n) begin
    if (!rst_n) begin
      thr  <= '0;
      sidx <= SIDX_INIT;
    end else begin
      // NOTE: Non-blocking assignments here, so every register samples pre-edge values
      // no matter how the always blocks are ordered.
      if (bus.enable)    thr  <= 16'(thr_prod >> 3);
      if (bus.cd3_valid) sidx <= sidx + 32'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk3 or negedge rst_n) begin
    if (!rst_n) state <= S_WAIT_THR;
    else        state <= state_nx;
  end

  // Next state and emit decision. Only a terminating sample of a long enough episode emits.
  always_comb begin
    // NOTE: Every output gets a default value first, so no path leaves one unassigned and
    // no latch is inferred.
    state_nx = state;
    emit     = 1'b0;
    case (state)
      S_WAIT_THR: if (bus.enable) state_nx = S_IDLE;
      S_IDLE:     if (bus.cd3_valid && above) state_nx = S_ABOVE;
      S_ABOVE: begin
        if (bus.cd3_valid && !above) begin
          if (len >= LEN_MIN) begin
            emit     = 1'b1;
            state_nx = S_REFRACT;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      S_REFRACT:  if (bus.cd3_valid && rcnt == RC_LAST) state_nx = S_IDLE;
      default:    state_nx = S_WAIT_THR;
    endcase
  end

  // Episode tracking: running maximum (first index wins on ties), length, refractory count.
  always_ff @(posedge clk3 or negedge rst_n) begin
    if (!rst_n) begin
      max_v   <= '0;
      max_idx <= '0;
      len     <= '0;
      rcnt    <= '0;
    end else if (bus.cd3_valid) begin
      case (state)
        S_IDLE: begin
          if (above) begin
            max_v   <= bus.cd3;
            max_idx <= sidx;
            len     <= 8'd1;
          end
        end
        S_ABOVE: begin
          if (above) begin
            if (len != 8'hFF) len <= len + 8'd1;
            if (bus.cd3 > max_v) begin
              max_v   <= bus.cd3;
              max_idx <= sidx;
            end
          end
        end
        default: ;
      endcase
      rcnt <= (state == S_REFRACT) ? rcnt + RC_W'(1) : '0;
    end
  end

`ifdef QRS_RR_INTERVAL_EN
  logic [31:0] rr_q;
  logic [31:0] last_addr;
  logic        have_last;
`endif

  // Single-slot output record. A concurrent accept frees the slot for a new emit.
  always_ff @(posedge clk3 or negedge rst_n) begin
    if (!rst_n) begin
      peak_valid_q <= 1'b0;
      peak_addr_q  <= '0;
      peak_val_q   <= '0;
      overflow_q   <= 1'b0;
`ifdef QRS_RR_INTERVAL_EN
      rr_q         <= '0;
      last_addr    <= '0;
      have_last    <= 1'b0;
`endif
    end else begin
      if (emit) begin
        if (!peak_valid_q || bus.peak_ready) begin
          peak_valid_q <= 1'b1;
          peak_addr_q  <= max_idx;
          peak_val_q   <= max_v;
`ifdef QRS_RR_INTERVAL_EN
          rr_q         <= have_last ? (max_idx - last_addr) : 32'd0;
          last_addr    <= max_idx;
          have_last    <= 1'b1;
`endif
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (peak_valid_q && bus.peak_ready) begin
        peak_valid_q <= 1'b0;
      end
    end
  end

  assign bus.peak_valid  = peak_valid_q;
  assign bus.peak_addr   = peak_addr_q;
  assign bus.peak_val    = peak_val_q;
  assign bus.overflow    = overflow_q;
`ifdef QRS_RR_INTERVAL_EN
  assign bus.rr_interval = rr_q;
`endif

endmodule

// File: tb/tb_qrs_peak_locator.sv
// tb_qrs_peak_locator: directed scenarios plus a randomized run for qrs_peak_locator.
// Every cycle is checked against an episode-level reference model. That model keeps the
// samples of the current episode in a queue and picks the peak from the finished episode.
// A second instance, with a preloaded sample index and a short refractory period, covers
// the sample-index wrap and the rr_interval output (built with QRS_RR_INTERVAL_EN).
module tb_qrs_peak_locator;
  localparam int THR_NUM   = 5;
  localparam int MIN_W     = 3;
  localparam int REFRACT   = 40;
  localparam int REFRACT_B = 8;

  logic clk3  = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk3 = ~clk3;

  qrs_peak_if bus ();
  qrs_peak_if bus_b ();

  qrs_peak_locator #(.THR_NUM(THR_NUM), .MIN_W(MIN_W), .REFRACT(REFRACT)) dut (
    .clk3(clk3), .rst_n(rst_n), .bus(bus)
  );
  qrs_peak_locator #(.THR_NUM(THR_NUM), .MIN_W(MIN_W), .REFRACT(REFRACT_B),
                     .SIDX_INIT(32'hFFFF_FFE0)) dut_b (
    .clk3(clk3), .rst_n(rst_n), .bus(bus_b)
  );

  int    n_checks = 0;
  int    n_pass   = 0;
  string cur      = "init";

  // ---------------- reference model (main instance) ----------------
  logic [15:0] m_thr;
  logic [31:0] m_sidx;
  bit          m_armed;
  int          m_refr_left;
  logic [15:0] ep_q[$];
  logic [31:0] ep_start;
  bit          m_pv;
  logic [31:0] m_addr;
  logic [15:0] m_val;
  bit          m_ovf;
`ifdef QRS_RR_INTERVAL_EN
  bit          m_have_last;
  logic [31:0] m_last;
  logic [31:0] m_rr;
`endif

  task automatic model_reset();
    m_thr = '0; m_sidx = '0; m_armed = 0; m_refr_left = 0; ep_q.delete(); ep_start = '0;
    m_pv = 0; m_addr = '0; m_val = '0; m_ovf = 0;
`ifdef QRS_RR_INTERVAL_EN
    m_have_last = 0; m_last = '0; m_rr = '0;
`endif
  endtask

  task automatic model_step(input bit en, input logic [15:0] mv, input bit v,
                            input logic [15:0] x, input bit rdy);
    bit          new_rec;
    logic [31:0] r_addr;
    logic [15:0] r_val;
    int          k;
    new_rec = 0; r_addr = '0; r_val = '0;
    if (v && m_armed) begin
      if (m_refr_left > 0) begin
        m_refr_left--;
      end else if (x > m_thr) begin
        if (ep_q.size() == 0) ep_start = m_sidx;
        ep_q.push_back(x);
      end else if (ep_q.size() != 0) begin
        if (ep_q.size() >= MIN_W) begin
          k = 0;
          for (int i = 1; i < ep_q.size(); i++) if (ep_q[i] > ep_q[k]) k = i;
          new_rec = 1; r_addr = ep_start + 32'(k); r_val = ep_q[k];
          m_refr_left = REFRACT;
        end
        ep_q.delete();
      end
    end
    if (new_rec) begin
      if (!m_pv || rdy) begin
        m_pv = 1; m_addr = r_addr; m_val = r_val;
`ifdef QRS_RR_INTERVAL_EN
        m_rr = m_have_last ? r_addr - m_last : 32'd0;
        m_last = r_addr; m_have_last = 1;
`endif
      end else begin
        m_ovf = 1;
      end
    end else if (m_pv && rdy) begin
      m_pv = 0;
    end
    if (v) m_sidx++;
    if (en) begin
      m_thr = 16'((32'(mv) * THR_NUM) >> 3);
      m_armed = 1;
    end
  endtask

  // One clock of stimulus on the main instance. Outputs are compared against the model at the
  // falling edge, and then the model advances over the coming rising edge.
  task automatic cyc(input bit en, input logic [15:0] mv, input bit v,
                     input logic [15:0] x, input bit rdy);
    bus.enable = en; bus.maxval = mv; bus.cd3_valid = v; bus.cd3 = x; bus.peak_ready = rdy;
    @(negedge clk3);
    n_checks++;
    if (bus.peak_valid !== m_pv)
      $display("FAIL %s peak_valid: got %b want %b", cur, bus.peak_valid, m_pv);
    else n_pass++;
    n_checks++;
    if (bus.overflow !== m_ovf)
      $display("FAIL %s overflow: got %b want %b", cur, bus.overflow, m_ovf);
    else n_pass++;
    if (m_pv) begin
      n_checks++;
      if (bus.peak_addr !== m_addr)
        $display("FAIL %s peak_addr: got %h want %h", cur, bus.peak_addr, m_addr);
      else n_pass++;
      n_checks++;
      if (bus.peak_val !== m_val)
        $display("FAIL %s peak_val: got %0d want %0d", cur, bus.peak_val, m_val);
      else n_pass++;
`ifdef QRS_RR_INTERVAL_EN
      n_checks++;
      if (bus.rr_interval !== m_rr)
        $display("FAIL %s rr_interval: got %h want %h", cur, bus.rr_interval, m_rr);
      else n_pass++;
`endif
    end
    model_step(en, mv, v, x, rdy);
    @(posedge clk3); #1;
  endtask

  task automatic samp(input logic [15:0] x, input bit rdy);
    cyc(1'b0, 16'd0, 1'b1, x, rdy);
  endtask

  task automatic samp_n(input int n, input logic [15:0] x, input bit rdy);
    for (int i = 0; i < n; i++) samp(x, rdy);
  endtask

  task automatic idle_inputs();
    bus.enable = 0; bus.maxval = '0; bus.cd3_valid = 0; bus.cd3 = '0; bus.peak_ready = 0;
    bus_b.enable = 0; bus_b.maxval = '0; bus_b.cd3_valid = 0; bus_b.cd3 = '0;
    bus_b.peak_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #2;
    @(negedge clk3); rst_n = 1'b1;
    @(posedge clk3); #1;
  endtask

  // Capture of the records that the wrap instance hands over.
  logic [31:0] cap_addr[$];
  logic [15:0] cap_val[$];
  logic [31:0] cap_rr[$];
  always @(negedge clk3) begin
    if (rst_n && bus_b.peak_valid === 1'b1 && bus_b.peak_ready === 1'b1) begin
      cap_addr.push_back(bus_b.peak_addr);
      cap_val.push_back(bus_b.peak_val);
`ifdef QRS_RR_INTERVAL_EN
      cap_rr.push_back(bus_b.rr_interval);
`else
      cap_rr.push_back(32'd0);
`endif
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    cur = "reset";
    idle_inputs();
    model_reset();
    #12;
    n_checks++;
    if (bus.peak_valid !== 1'b0) $display("FAIL reset peak_valid: got %b want 0", bus.peak_valid);
    else n_pass++;
    n_checks++;
    if (bus.peak_addr !== 32'd0) $display("FAIL reset peak_addr: got %h want 0", bus.peak_addr);
    else n_pass++;
    n_checks++;
    if (bus.peak_val !== 16'd0) $display("FAIL reset peak_val: got %h want 0", bus.peak_val);
    else n_pass++;
    n_checks++;
    if (bus.overflow !== 1'b0) $display("FAIL reset overflow: got %b want 0", bus.overflow);
    else n_pass++;
    @(negedge clk3); rst_n = 1'b1;
    @(posedge clk3); #1;
  endtask

  task automatic test_single_peak();
    cur = "single_peak";
    do_reset();
    cyc(1'b1, 16'd800, 1'b0, 16'd0, 1'b0);
    samp_n(9, 16'd500, 1'b0);  // equal to the threshold: must not start an episode
    samp(16'd100, 1'b0);
    samp(16'd600, 1'b0); samp(16'd900, 1'b0); samp(16'd700, 1'b0); samp(16'd400, 1'b0);
    n_checks++;
    if (bus.peak_valid !== 1'b1) $display("FAIL single_peak latency: got %b want 1", bus.peak_valid);
    else n_pass++;
    n_checks++;
    if (bus.peak_addr !== 32'd11) $display("FAIL single_peak addr: got %0d want 11", bus.peak_addr);
    else n_pass++;
    n_checks++;
    if (bus.peak_val !== 16'd900) $display("FAIL single_peak val: got %0d want 900", bus.peak_val);
    else n_pass++;
    cyc(1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
    n_checks++;
    if (bus.peak_valid !== 1'b0) $display("FAIL single_peak accept: got %b want 0", bus.peak_valid);
    else n_pass++;
  endtask

  task automatic test_threshold_edge();
    cur = "threshold_501";
    samp_n(REFRACT, 16'd0, 1'b0);
    samp_n(3, 16'd501, 1'b0);
    samp(16'd0, 1'b0);
    n_checks++;
    if (bus.peak_val !== 16'd501 || bus.peak_valid !== 1'b1)
      $display("FAIL threshold_501 record: got valid %b val %0d want valid 1 val 501",
               bus.peak_valid, bus.peak_val);
    else n_pass++;
    cyc(1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
  endtask

  task automatic test_short_and_tie();
    logic [31:0] a;
    cur = "short_tie";
    samp_n(REFRACT, 16'd0, 1'b0);
    samp(16'd600, 1'b0); samp(16'd600, 1'b0); samp(16'd300, 1'b0);
    n_checks++;
    if (bus.peak_valid !== 1'b0) $display("FAIL short_episode valid: got %b want 0", bus.peak_valid);
    else n_pass++;
    a = m_sidx + 32'd1;
    samp(16'd700, 1'b0); samp(16'd800, 1'b0); samp(16'd800, 1'b0); samp(16'd300, 1'b0);
    n_checks++;
    if (bus.peak_addr !== a) $display("FAIL tie addr: got %0d want %0d", bus.peak_addr, a);
    else n_pass++;
    cyc(1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
  endtask

  task automatic test_refract_overflow();
    logic [31:0] a;
    cur = "refract_overflow";
    samp_n(REFRACT, 16'd100, 1'b0);
    a = m_sidx + 32'd1;
    samp(16'd600, 1'b0); samp(16'd900, 1'b0); samp(16'd700, 1'b0); samp(16'd100, 1'b0);
    samp_n(5, 16'd100, 1'b0);
    samp_n(3, 16'd900, 1'b0); samp(16'd100, 1'b0);  // inside the refractory period
    n_checks++;
    if (bus.overflow !== 1'b0) $display("FAIL refract overflow: got %b want 0", bus.overflow);
    else n_pass++;
    samp_n(REFRACT, 16'd100, 1'b0);
    samp(16'd600, 1'b0); samp(16'd1000, 1'b0); samp(16'd700, 1'b0); samp(16'd100, 1'b0);
    n_checks++;
    if (bus.overflow !== 1'b1) $display("FAIL overflow set: got %b want 1", bus.overflow);
    else n_pass++;
    n_checks++;
    if (bus.peak_addr !== a || bus.peak_val !== 16'd900)
      $display("FAIL overflow held: got %0d/%0d want %0d/900", bus.peak_addr, bus.peak_val, a);
    else n_pass++;
    cyc(1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
  endtask

  task automatic test_back_to_back();
    cur = "back_to_back";
    do_reset();
    cyc(1'b1, 16'd800, 1'b0, 16'd0, 1'b0);
    samp(16'd600, 1'b0); samp(16'd900, 1'b0); samp(16'd700, 1'b0); samp(16'd100, 1'b0);
    samp_n(REFRACT, 16'd100, 1'b0);
    samp(16'd600, 1'b0); samp(16'd950, 1'b0); samp(16'd700, 1'b0);
    samp(16'd100, 1'b1);  // emit coincides with accept of the first record
    n_checks++;
    if (bus.peak_valid !== 1'b1 || bus.peak_val !== 16'd950)
      $display("FAIL back_to_back load: got valid %b val %0d want 1/950",
               bus.peak_valid, bus.peak_val);
    else n_pass++;
    n_checks++;
    if (bus.overflow !== 1'b0) $display("FAIL back_to_back overflow: got %b want 0", bus.overflow);
    else n_pass++;
    cyc(1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
  endtask

  task automatic test_thr_update();
    cur = "thr_update";
    samp_n(REFRACT, 16'd0, 1'b0);
    samp_n(3, 16'd600, 1'b0);
    cyc(1'b1, 16'd8000, 1'b1, 16'd550, 1'b0);  // same cycle: still compared against 500
    n_checks++;
    if (bus.peak_valid !== 1'b0) $display("FAIL thr_update old_thr: got %b want 0", bus.peak_valid);
    else n_pass++;
    samp(16'd550, 1'b0);  // now below the new 5000 threshold
    n_checks++;
    if (bus.peak_valid !== 1'b1 || bus.peak_val !== 16'd600)
      $display("FAIL thr_update emit: got valid %b val %0d want 1/600",
               bus.peak_valid, bus.peak_val);
    else n_pass++;
    cyc(1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
    cyc(1'b1, 16'd800, 1'b0, 16'd0, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    cur = "reset_mid";
    samp_n(REFRACT, 16'd0, 1'b0);
    samp(16'd600, 1'b0); samp(16'd900, 1'b0); samp(16'd700, 1'b0); samp(16'd100, 1'b0);
    samp_n(REFRACT, 16'd0, 1'b0);
    samp(16'd600, 1'b0); samp(16'd900, 1'b0);  // mid-episode, with a record still pending
    idle_inputs();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (bus.peak_valid !== 1'b0 || bus.peak_addr !== 32'd0 || bus.peak_val !== 16'd0 ||
        bus.overflow !== 1'b0)
      $display("FAIL reset_mid outputs: got %b %h %h %b want all 0",
               bus.peak_valid, bus.peak_addr, bus.peak_val, bus.overflow);
    else n_pass++;
    model_reset();
    @(negedge clk3); rst_n = 1'b1;
    @(posedge clk3); #1;
    samp(16'd600, 1'b0); samp(16'd900, 1'b0); samp(16'd700, 1'b0); samp(16'd100, 1'b0);
    n_checks++;
    if (bus.peak_valid !== 1'b0) $display("FAIL reset_mid wait_thr: got %b want 0", bus.peak_valid);
    else n_pass++;
    cyc(1'b1, 16'd800, 1'b0, 16'd0, 1'b0);
    a = m_sidx + 32'd1;
    samp(16'd600, 1'b0); samp(16'd900, 1'b0); samp(16'd700, 1'b0); samp(16'd100, 1'b0);
    n_checks++;
    if (bus.peak_valid !== 1'b1 || bus.peak_addr !== a)
      $display("FAIL reset_mid rearm: got valid %b addr %0d want 1/%0d",
               bus.peak_valid, bus.peak_addr, a);
    else n_pass++;
    cyc(1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
  endtask

  task automatic test_random();
    bit          en, v, rdy;
    logic [15:0] mv, x;
    cur = "random";
    do_reset();
    cyc(1'b1, 16'd1200, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      en  = ($urandom_range(0, 49) == 0);
      mv  = 16'($urandom_range(400, 4000));
      v   = ($urandom_range(0, 3) != 0);
      x   = 16'($urandom_range(0, 3000));
      rdy = ($urandom_range(0, 3) == 0);
      cyc(en, mv, v, x, rdy);
    end
  endtask

  task automatic test_wrap_rr();
    logic [15:0] x;
    cur = "wrap_rr";
    do_reset();
    cap_addr.delete(); cap_val.delete(); cap_rr.delete();
    bus_b.enable = 1; bus_b.maxval = 16'd800;
    @(negedge clk3); @(posedge clk3); #1;
    bus_b.enable = 0;
    // Sample offset k has index 0xFFFFFFE0 + k: peaks at 0xFFFFFFF0 (k=0x10) and 0x10 (k=0x30).
    for (int k = 0; k < 64; k++) begin
      case (k)
        15, 47:  x = 16'd600;
        16:      x = 16'd900;
        48:      x = 16'd950;
        17, 49:  x = 16'd700;
        default: x = 16'd100;
      endcase
      bus_b.cd3_valid = 1; bus_b.cd3 = x;
      @(negedge clk3); @(posedge clk3); #1;
    end
    bus_b.cd3_valid = 0;
    @(negedge clk3); @(posedge clk3); #1;
    n_checks++;
    if (cap_addr.size() != 2) $display("FAIL wrap count: got %0d want 2", cap_addr.size());
    else n_pass++;
    if (cap_addr.size() >= 2) begin
      n_checks++;
      if (cap_addr[0] !== 32'hFFFF_FFF0 || cap_val[0] !== 16'd900)
        $display("FAIL wrap first: got %h/%0d want fffffff0/900", cap_addr[0], cap_val[0]);
      else n_pass++;
      n_checks++;
      if (cap_addr[1] !== 32'h0000_0010 || cap_val[1] !== 16'd950)
        $display("FAIL wrap second: got %h/%0d want 00000010/950", cap_addr[1], cap_val[1]);
      else n_pass++;
`ifdef QRS_RR_INTERVAL_EN
      n_checks++;
      if (cap_rr[0] !== 32'd0) $display("FAIL rr first: got %h want 0", cap_rr[0]);
      else n_pass++;
      n_checks++;
      if (cap_rr[1] !== 32'h20) $display("FAIL rr second: got %h want 20", cap_rr[1]);
      else n_pass++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single_peak();
    test_threshold_edge();
    test_short_and_tie();
    test_refract_overflow();
    test_back_to_back();
    test_thr_update();
    test_reset_mid();
    test_random();
    test_wrap_rr();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
